// File: rtl/div_unit_pkg.sv
// Shared encodings and constants for the EX-stage radix-2 restoring divider.
// Imported by div_unit for its state type and control-level constants.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        Stop              = 1'b1;
    localparam logic        NoStop            = 1'b0;
    localparam logic        RstActiveLow      = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}
// and drives the EX stall request while a divide is in flight.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    div_state_e state_q, state_d;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   dvsr_q, dvsr_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_mag, op2_mag;
    logic [DATA_W:0]     partial;
    logic [DATA_W-1:0]   step_rem, step_quo;
    logic [DATA_W-1:0]   fin_rem, fin_quo;

    // Operand magnitudes; -MIN wraps to MIN, which is the correct unsigned magnitude.
    always_comb begin
        op1_neg = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg = signed_div_i & opdata2_i[DATA_W-1];
        op1_mag = op1_neg ? -opdata1_i : opdata1_i;
        op2_mag = op2_neg ? -opdata2_i : opdata2_i;
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        partial = {rem_q, quo_q[DATA_W-1]};
        if (partial >= {1'b0, dvsr_q}) begin
            step_rem = partial[DATA_W-1:0] - dvsr_q;
            step_quo = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            step_rem = partial[DATA_W-1:0];
            step_quo = {quo_q[DATA_W-2:0], 1'b0};
        end
        fin_quo = neg_quo_q ? -step_quo : step_quo;
        fin_rem = neg_rem_q ? -step_rem : step_rem;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    neg_quo_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                    dvsr_d    = op2_mag;
                    quo_d     = op1_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                result_d = {DATA_W'(ZeroWord), DATA_W'(ZeroWord)};
                ready_d  = DivResultReady;
                state_d  = DivEnd;
            end
            DivOn: begin
                if (annul_i || start_i == DivStop) begin
                    state_d = DivFree;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        result_d = {fin_rem, fin_quo};
                        ready_d  = DivResultReady;
                        state_d  = DivEnd;
                    end
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    state_d  = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstActiveLow) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    // Drops in the cycle ready_o rises so EX consumes the result exactly once.
    assign stallreq_o = (start_i && !annul_i && !ready_q) ? Stop : NoStop;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: random and directed divides against an arithmetic model,
// with latency, stall length, abort and asynchronous reset behaviour.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    div_unit #(
        .DATA_W (32),
        .CNT_W  (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Reference: truncating division, remainder takes the dividend's sign, x/0 = 0.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    // Monitor: edge counts since start was sampled, and result check on each ready rise.
    int lat_cnt   = 0;
    int stall_cnt = 0;
    bit ready_prev = 1'b0;
    exp_t mon_e;

    always @(posedge clk or negedge rst) begin
        if (!rst || !start_i || annul_i) begin
            lat_cnt   = 0;
            stall_cnt = 0;
        end else begin
            if (!ready_o) lat_cnt++;
            if (stallreq_o) stall_cnt++;
        end
    end

    always @(negedge clk) begin
        if (ready_o && !ready_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ready: ready_o=1 result_o=%h, expected no result", result_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", result_o, mon_e.res);
                check("latency", 64'(lat_cnt), 64'(mon_e.lat));
                check("stall_cycles", 64'(stall_cnt), 64'(mon_e.lat));
                check("stall_low_at_ready", 64'(stallreq_o), 64'd0);
            end
        end
        ready_prev = ready_o;
    end

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    task automatic wait_ready(output bit got);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL timeout: ready_o=0 after 40 cycles, expected 1");
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble);
        exp_t e;
        bit   got;
        e.res = ref_div(s, a, b);
        e.lat = (b == 32'd0) ? 2 : 33;
        exp_q.push_back(e);
        issue(s, a, b);
        @(posedge clk);
        if (scramble) begin
            @(negedge clk);
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom);
        end
        wait_ready(got);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("clear_ready", 64'(ready_o), 64'd0);
        check("clear_result", result_o, 64'd0);
    endtask

    initial begin
        bit          got;
        exp_t        e;
        logic [31:0] a, b;
        bit          s;

        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #12;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        do_div(1'b0, 32'd100, 32'd7, 1'b1);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        do_div(1'b0, 32'h0000_1234, 32'd0, 1'b1);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Abort after ten iterations; no result may ever appear.
        issue(1'b0, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_idle_ready", 64'(ready_o), 64'd0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Asynchronous reset mid-divide, away from any clock edge.
        issue(1'b0, 32'd100, 32'd7);
        repeat (21) @(posedge clk);
        #3;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("midreset_ready", 64'(ready_o), 64'd0);
        check("midreset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_div(1'b0, 32'd100, 32'd7, 1'b0);

        // Asynchronous reset while a result is held must clear it at once.
        e.res = ref_div(1'b1, 32'hFFFF_FF00, 32'd3);
        e.lat = 33;
        exp_q.push_back(e);
        issue(1'b1, 32'hFFFF_FF00, 32'd3);
        wait_ready(got);
        @(negedge clk);
        #1;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("endreset_ready", 64'(ready_o), 64'd0);
        check("endreset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'd1;
                1:       b = 32'($urandom_range(1, 50));
                2:       b = -32'($urandom_range(1, 50));
                default: b = $urandom;
            endcase
            do_div(s, a, b, 1'b1);
        end

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider used by the EX stage for DIV/DIVU.
- It is the direct source of the EX stall request consumed by the pipeline controller.
- While a divide is in progress, stallreq_o holds the pipeline.
- On completion it returns {remainder, quotient} for the HI/LO write path.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  divide request; held high by EX until ready_o is seen.
- annul_i  input  1  abort the current divide (flush or exception).
- result_o  output  2*DATA_W  {remainder, quotient}; valid when ready_o=1.
- ready_o  output  1  result valid.
- stallreq_o  output  1  stall request toward the pipeline controller.

Behaviour:
- Clock and reset: one clock domain. rst low forces, asynchronously, state=FREE, cnt=0, result_o=0, ready_o=0, internal registers=0. Reset mid-divide discards all work.
- State FREE:
  - On start_i=1 and annul_i=0, capture operands.
  - If signed_div_i=1, store magnitudes and record sign_q = op1[31]^op2[31] and sign_r = op1[31].
  - If opdata2_i=0, go to BYZERO; otherwise go to ON with cnt=0, rem=0, quo=|op1|.
- State BYZERO: next edge goes to END with result {0,0}. This state ignores annul_i.
- State ON, one iteration per cycle:
  - Form partial = {rem, quo[MSB]} (DATA_W+1 bits).
  - If partial >= divisor: rem = partial - divisor and shift 1 into quo; else rem = partial[DATA_W-1:0] and shift 0 into quo.
  - cnt increments each iteration.
  - On the iteration where cnt = DATA_W-1 (32nd iteration), apply sign correction: quotient negated if sign_q, remainder negated if sign_r, signed only. Then go to END.
  - Abort: annul_i=1 or start_i=0 in ON goes to FREE next edge. Outputs stay 0 and no result is produced.
- State END: result_o and ready_o are registered on entry to END and held. Leave END for FREE when start_i=0; the same edge clears result_o and ready_o.
- Latency, counted from the first edge that samples start_i=1 as edge 1:
  - Normal divide: ready_o is high after edge 33.
  - Divide by zero: ready_o is high after edge 2.
- stallreq_o is combinational: start_i & ~annul_i & ~ready_o. It goes low in the same cycle ready_o rises, so EX consumes the result exactly once.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (two's-complement wrap), remainder 0. No trap.
- Divide by zero returns 0. Architectural behaviour is UNPREDICTABLE and this is the decided value.
- Operand changes after capture are ignored.
- start_i rising in the cycle after END→FREE starts a new divide normally.

Decomposition:
- Shared defines file:
  - State encodings DivFree, DivByZero, DivOn, DivEnd (2 bits).
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
  - ZeroWord.
  - Reuse the existing Stop/NoStop and reset-level macros, adding a RstActiveLow level for this block.
- No sub-module is needed. The subtract/compare step is one always block. Optionally factor it as div_step (combinational, DATA_W+1 compare/subtract) if it is reused by a future remainder-only op.

Test Plan:
- Unsigned: op1=100, op2=7, start held → stallreq_o high for 33 cycles. ready_o rises after edge 33 with result_o={32'd2, 32'd14}. Drop start → ready_o=0 and result_o=0 next edge.
- Signed: op1=0xFFFFFFF9 (-7), op2=2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Then op1=7, op2=0xFFFFFFFE gives quotient 0xFFFFFFFD, remainder 1.
- Divide by zero: op1=0x1234, op2=0 → ready_o after edge 2, result_o=0, stallreq_o high for exactly 2 cycles.
- Abort: annul_i pulsed at iteration 10 → state FREE, ready_o never rises. A following divide 0xFFFFFFFF/1 (unsigned) returns quotient 0xFFFFFFFF, remainder 0 with full 33-cycle latency.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned same operands → quotient 0, remainder 0x80000000.
- Reset: rst driven low asynchronously at iteration 20 (mid-cycle) → all outputs 0 immediately, with no wait for a clock edge. After release, a new 100/7 completes correctly.
